// File: rtl/ram32_bus_arbiter.sv
// Shares the single-port RAM32 macro between the host byte port, SERV ibus and SERV dbus.
// Fixed priority host > dbus > ibus, with starvation counters forcing dbus/ibus through.
module ram32_bus_arbiter #(
  parameter int ADDR_W     = 5,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W+1:0] host_adr,
  input  logic [7:0]        host_wdata,
  output logic [7:0]        host_rdata,
  output logic              host_ack,
  input  logic              ibus_cyc,
  input  logic [31:0]       ibus_adr,
  output logic [31:0]       ibus_rdt,
  output logic              ibus_ack,
  input  logic              dbus_cyc,
  input  logic              dbus_we,
  input  logic [3:0]        dbus_sel,
  input  logic [31:0]       dbus_adr,
  input  logic [31:0]       dbus_dat,
  output logic [31:0]       dbus_rdt,
  output logic              dbus_ack,
  output logic              ram_en,
  output logic [ADDR_W-1:0] ram_a,
  output logic [3:0]        ram_we,
  output logic [31:0]       ram_di,
  input  logic [31:0]       ram_do,
  output logic [1:0]        gnt
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  typedef enum logic {IDLE, RESP} state_t;
  typedef enum logic [1:0] {G_NONE, G_HOST, G_DBUS, G_IBUS} grant_t;

  state_t        r_state;
  grant_t        r_gnt;
  logic [1:0]    r_off;
  logic [SW-1:0] r_starve_d;
  logic [SW-1:0] r_starve_i;

  grant_t        w_win;
  logic          w_resp;
  logic          w_unused;

  assign w_unused = ^{ibus_adr[31:ADDR_W+2], ibus_adr[1:0],
                      dbus_adr[31:ADDR_W+2], dbus_adr[1:0]};

  // A saturated counter only forces a win while its requester is still asking.
  always_comb begin
    w_win = G_NONE;
    if (r_state == IDLE) begin
      if (dbus_cyc && r_starve_d == SMAX)      w_win = G_DBUS;
      else if (ibus_cyc && r_starve_i == SMAX) w_win = G_IBUS;
      else if (host_req)                       w_win = G_HOST;
      else if (dbus_cyc)                       w_win = G_DBUS;
      else if (ibus_cyc)                       w_win = G_IBUS;
    end
  end

  always_comb begin
    ram_en = 1'b0;
    ram_a  = '0;
    ram_we = '0;
    ram_di = '0;
    if (rst_n) begin
      case (w_win)
        G_HOST: begin
          ram_en = 1'b1;
          ram_a  = host_adr[ADDR_W+1:2];
          ram_we = host_we ? (4'b0001 << host_adr[1:0]) : 4'b0000;
          ram_di = {4{host_wdata}};
        end
        G_DBUS: begin
          ram_en = 1'b1;
          ram_a  = dbus_adr[ADDR_W+1:2];
          ram_we = dbus_we ? dbus_sel : 4'b0000;
          ram_di = dbus_dat;
        end
        G_IBUS: begin
          ram_en = 1'b1;
          ram_a  = ibus_adr[ADDR_W+1:2];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_gnt      <= G_NONE;
      r_off      <= '0;
      r_starve_d <= '0;
      r_starve_i <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_win != G_NONE) begin
            r_state <= RESP;
            r_gnt   <= w_win;
            r_off   <= host_adr[1:0];
          end
          if (!dbus_cyc || w_win == G_DBUS) r_starve_d <= '0;
          else if (r_starve_d != SMAX)      r_starve_d <= r_starve_d + 1'b1;
          if (!ibus_cyc || w_win == G_IBUS) r_starve_i <= '0;
          else if (r_starve_i != SMAX)      r_starve_i <= r_starve_i + 1'b1;
        end
        RESP: r_state <= IDLE;
      endcase
    end
  end

  // rst_n also gates the response so an ack cycle cut short by reset shows nothing.
  assign w_resp     = rst_n && (r_state == RESP);
  assign host_ack   = w_resp && (r_gnt == G_HOST);
  assign dbus_ack   = w_resp && (r_gnt == G_DBUS);
  assign ibus_ack   = w_resp && (r_gnt == G_IBUS);
  assign host_rdata = host_ack ? ram_do[{r_off, 3'b000} +: 8] : '0;
  assign dbus_rdt   = dbus_ack ? ram_do : '0;
  assign ibus_rdt   = ibus_ack ? ram_do : '0;
  assign gnt        = r_gnt;

endmodule

// File: doc/ram32_bus_arbiter.md
Name: ram32_bus_arbiter

Overview:
- Shares the single-port RAM32 macro between three requesters: external host byte port (pins), SERV instruction bus, SERV data bus.
- Fixed priority host > dbus > ibus, with anti-starvation counters so ibus and dbus always progress.
- Drives RAM32 enable, word address, byte write enables and write data; returns Wishbone-classic acks and read data.
- Sits between the top-level pin decode, serv_top and RAM32.

Parameters:
- ADDR_W, 5, RAM word-address width (32 words); upper address bits ignored, so addresses wrap.
- STARVE_MAX, 4, consecutive lost arbitrations after which a waiting dbus/ibus requester is forced to win.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- host_req  in  1  host access request (level, held until host_ack)
- host_we  in  1  1=byte write, 0=byte read
- host_adr  in  ADDR_W+2  byte address
- host_wdata  in  8  write byte
- host_rdata  out  8  read byte, valid only while host_ack=1, else 0
- host_ack  out  1  one-cycle completion pulse
- ibus_cyc  in  1  SERV instruction fetch request
- ibus_adr  in  32  byte address; bits [ADDR_W+1:2] used
- ibus_rdt  out  32  fetch data, valid with ibus_ack, else 0
- ibus_ack  out  1  one-cycle completion pulse
- dbus_cyc  in  1  SERV data request
- dbus_we  in  1  1=write
- dbus_sel  in  4  byte lane select
- dbus_adr  in  32  byte address; bits [ADDR_W+1:2] used
- dbus_dat  in  32  write data
- dbus_rdt  out  32  read data, valid with dbus_ack, else 0
- dbus_ack  out  1  one-cycle completion pulse
- ram_en  out  1  RAM32 EN0
- ram_a  out  ADDR_W  RAM32 A0
- ram_we  out  4  RAM32 WE0
- ram_di  out  32  RAM32 Di0
- ram_do  in  32  RAM32 Do0, valid the cycle after an enabled access
- gnt  out  2  current/last grant: 0 none, 1 host, 2 dbus, 3 ibus (status)

Behaviour:
- FSM states: IDLE, RESP.
- IDLE: if any request is pending, select a winner combinationally and drive RAM in the same cycle (ram_en=1, ram_a, ram_we, ram_di). Register the winner and the host byte offset, then go to RESP. If no request is pending, ram_en=0, ram_we=0, stay in IDLE.
- RESP: the winner's ack=1 for exactly one cycle. The winner's rdt/rdata = ram_do (host: byte ram_do[8*off+:8]). Then go to IDLE. ram_en=0 and ram_we=0 in RESP.
- Latency: grant to ack is 1 cycle. Each access takes 2 cycles, so peak throughput is one access per 2 cycles.
- Requesters deassert cyc/req the cycle after ack. In IDLE a still-high request is a new access.
- Write mapping:
  - host: ram_di={4{host_wdata}}, ram_we=host_we ? (4'b0001<<host_adr[1:0]) : 0.
  - dbus: ram_di=dbus_dat, ram_we=dbus_we ? dbus_sel : 0.
  - ibus: ram_we=0.
- Writes are acked like reads; read data returned on a write ack is don't-care.
- Arbitration:
  - Base priority is host > dbus > ibus.
  - starve_d/starve_i (width clog2(STARVE_MAX+1)) increment when their requester is pending in IDLE and loses. They saturate at STARVE_MAX.
  - A counter clears when its requester is granted or its request is low in IDLE.
  - If starve_d==STARVE_MAX, dbus wins. Else if starve_i==STARVE_MAX, ibus wins. Else base priority applies.
- Non-winning acks/rdt are 0 at all times. Acks are never asserted outside RESP.
- gnt holds the registered winner from IDLE grant until the next grant.
- Reset (rst_n=0 at a clock edge, including mid-RESP) sets:
  - state=IDLE
  - all acks 0, all rdt/rdata 0
  - ram_en=0, ram_we=0, ram_a=0, ram_di=0
  - gnt=0
  - both starve counters 0
- An access in flight at reset is dropped, with no ack. RAM contents are not touched beyond a write already issued.

Test Plan:
- Host write then read: host writes byte 0xA5 at adr 0x06 → ram_we=4'b0100, ram_a=1, ram_di=0xA5A5A5A5, host_ack 1 cycle later. Host reads adr 0x06 → host_rdata=0xA5 with host_ack.
- dbus word write then ibus fetch: dbus writes 0x12345678, sel=4'hF, adr 0x10 → ram_a=4, ack after 1 cycle. ibus fetches adr 0x10 → ibus_rdt=0x12345678, ibus_ack 1 cycle, rdt=0 otherwise.
- Simultaneous host/dbus/ibus requests held: grant order host, dbus, ibus, each ack spaced 2 cycles apart. No two acks assert in the same cycle.
- Starvation: host_req and ibus_cyc held continuously with STARVE_MAX=4 → 4 host acks, then an ibus ack, then host resumes. starve_i returns to 0.
- Partial dbus write: sel=4'b0010, dat=0x0000AB00 over existing 0x12345678 → subsequent read returns 0x1234AB78.
- Reset mid-RESP: assert rst_n=0 in the RESP cycle → no ack that cycle or after. On release, outputs are 0, FSM is in IDLE, and a fresh request completes normally.
